// File: rtl/bomb_fuse_logic_pkg.sv
// Shared map tile codes and the bomb/explosion FSM state encodings.
// Pure type/constant package; no logic, no latency.
package bomb_fuse_logic_pkg;

    localparam logic [1:0] TILE_FREE  = 2'd0;
    localparam logic [1:0] TILE_WALL  = 2'd1;
    localparam logic [1:0] TILE_BRICK = 2'd2;
    localparam logic [1:0] TILE_BOMB  = 2'd3;

    typedef enum logic [2:0] {
        BF_IDLE,
        BF_READ,
        BF_CHECK,
        BF_FUSE,
        BF_WAIT,
        BF_FIRE,
        BF_CLEAR
    } bomb_fuse_state_t;

    typedef enum logic [1:0] {
        EXP_IDLE,
        EXP_ACTIVE,
        EXP_FREE
    } explosion_state_t;

endpackage

// File: rtl/bomb_fuse_logic_player_tile_addr.sv
// Pixel position to the linear address of the tile under the sprite centre.
// Purely combinational, zero latency; no handshake.
module player_tile_addr #(
    parameter int NUM_COL    = 19,
    parameter int TILE_PX    = 64,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 48,
    parameter int ADDR_WIDTH = 8,
    localparam int TILE_SHIFT = $clog2(TILE_PX)
) (
    input  logic [10:0]           pixel_x_i,
    input  logic [9:0]            pixel_y_i,
    output logic [ADDR_WIDTH-1:0] tile_addr_o
);

    logic [11:0] centre_x;
    logic [10:0] centre_y;
    logic [11:0] col;
    logic [10:0] row;

    // One extra bit so the half-sprite offset never wraps at the far edge.
    assign centre_x = {1'b0, pixel_x_i} + 12'(SPRITE_W / 2);
    assign centre_y = {1'b0, pixel_y_i} + 11'(SPRITE_H / 2);
    assign col      = centre_x >> TILE_SHIFT;
    assign row      = centre_y >> TILE_SHIFT;

    assign tile_addr_o = ADDR_WIDTH'(24'(row) * 24'(NUM_COL) + 24'(col));

endmodule

// File: rtl/bomb_fuse_logic.sv
// Places one bomb on a free tile, runs its fuse on frame ticks, then requests the explosion.
// Place->BOMB write 2 cycles after the edge; trigger waits for exp_busy low; presses outside IDLE are dropped.
module bomb_fuse_logic
    import bomb_fuse_logic_pkg::*;
#(
    parameter int NUM_ROW       = 11,
    parameter int NUM_COL       = 19,
    parameter int TILE_PX       = 64,
    parameter int MAP_MEM_WIDTH = 2,
    parameter int SPRITE_W      = 32,
    parameter int SPRITE_H      = 48,
    parameter int FUSE_TIME     = 3,
    localparam int DEPTH        = NUM_ROW * NUM_COL,
    localparam int ADDR_WIDTH   = $clog2(DEPTH),
    localparam int TILE_SHIFT   = $clog2(TILE_PX),
    localparam int FUSE_TICKS   = FUSE_TIME * 60,
    localparam int FUSE_CNT_W   = $clog2(FUSE_TICKS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     game_over,
    input  logic                     place_bomb,
    input  logic [10:0]              player_x,
    input  logic [9:0]               player_y,
    input  logic                     exp_busy,
    input  logic [MAP_MEM_WIDTH-1:0] map_rdata,
    output logic [ADDR_WIDTH-1:0]    map_raddr,
    output logic                     map_we,
    output logic [ADDR_WIDTH-1:0]    map_waddr,
    output logic [MAP_MEM_WIDTH-1:0] map_wdata,
    output logic                     trigger_explosion,
    output logic [ADDR_WIDTH-1:0]    explosion_addr,
    output logic                     bomb_active
);

    localparam logic [FUSE_CNT_W-1:0] FUSE_LAST = FUSE_CNT_W'(FUSE_TICKS - 1);

    bomb_fuse_state_t        st_q;
    logic [FUSE_CNT_W-1:0]   fuse_cnt_q;
    logic [ADDR_WIDTH-1:0]   bomb_addr_q;
    logic                    place_q;
    logic [ADDR_WIDTH-1:0]   player_addr;
    logic                    req;
    logic                    tile_free;

    player_tile_addr #(
        .NUM_COL    (NUM_COL),
        .TILE_PX    (TILE_PX),
        .SPRITE_W   (SPRITE_W),
        .SPRITE_H   (SPRITE_H),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_player_tile_addr (
        .pixel_x_i   (player_x),
        .pixel_y_i   (player_y),
        .tile_addr_o (player_addr)
    );

    assign req       = place_bomb & ~place_q;
    assign tile_free = (map_rdata == MAP_MEM_WIDTH'(TILE_FREE));

    always_ff @(posedge clk) begin
        if (rst || game_over) begin
            st_q        <= BF_IDLE;
            fuse_cnt_q  <= '0;
            bomb_addr_q <= '0;
            place_q     <= 1'b0;
        end else begin
            place_q <= place_bomb;
            case (st_q)
                BF_IDLE: begin
                    if (req) begin
                        bomb_addr_q <= player_addr;
                        st_q        <= BF_READ;
                    end
                end
                BF_READ: st_q <= BF_CHECK;
                BF_CHECK: begin
                    if (tile_free) begin
                        fuse_cnt_q <= '0;
                        st_q       <= BF_FUSE;
                    end else begin
                        st_q <= BF_IDLE;
                    end
                end
                BF_FUSE: begin
                    if (tick) begin
                        fuse_cnt_q <= fuse_cnt_q + FUSE_CNT_W'(1);
                        if (fuse_cnt_q == FUSE_LAST) begin
                            st_q <= exp_busy ? BF_WAIT : BF_FIRE;
                        end
                    end
                end
                // Trigger only after an idle cycle so the explosion block is ready to sample it.
                BF_WAIT:  if (!exp_busy) st_q <= BF_FIRE;
                BF_FIRE:  st_q <= BF_CLEAR;
                BF_CLEAR: st_q <= BF_IDLE;
                default:  st_q <= BF_IDLE;
            endcase
        end
    end

    always_comb begin
        map_we            = 1'b0;
        map_waddr         = bomb_addr_q;
        map_wdata         = MAP_MEM_WIDTH'(TILE_FREE);
        trigger_explosion = 1'b0;
        explosion_addr    = '0;
        case (st_q)
            BF_CHECK: begin
                map_we    = tile_free;
                map_wdata = tile_free ? MAP_MEM_WIDTH'(TILE_BOMB) : MAP_MEM_WIDTH'(TILE_FREE);
            end
            BF_FIRE: begin
                trigger_explosion = 1'b1;
                explosion_addr    = bomb_addr_q;
            end
            BF_CLEAR: map_we = 1'b1;
            default: ;
        endcase
    end

    assign map_raddr   = bomb_addr_q;
    assign bomb_active = (st_q == BF_FUSE) || (st_q == BF_WAIT) ||
                         (st_q == BF_FIRE) || (st_q == BF_CLEAR);

endmodule

// File: tb/tb_bomb_fuse_logic.sv
// Directed/random bench for bomb_fuse_logic with a behavioural map BRAM and event counters.
module tb_bomb_fuse_logic;

    localparam int NUM_ROW    = 11;
    localparam int NUM_COL    = 19;
    localparam int TILE_PX    = 64;
    localparam int SW         = 32;
    localparam int SH         = 48;
    localparam int FUSE_TICKS = 180;
    localparam int DEPTH      = NUM_ROW * NUM_COL;
    localparam int AW         = 8;

    logic          clk = 1'b0;
    logic          rst, tick, game_over, place_bomb, exp_busy;
    logic [10:0]   player_x;
    logic [9:0]    player_y;
    logic [1:0]    map_rdata, map_wdata;
    logic [AW-1:0] map_raddr, map_waddr, explosion_addr;
    logic          map_we, trigger_explosion, bomb_active;

    int n_assert = 0;
    int n_fail   = 0;
    int bomb_wr  = 0;
    int free_wr  = 0;
    int trig_cnt = 0;

    logic [1:0]    mem [DEPTH];
    logic          tb_we  = 1'b0;
    logic          tb_clr = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [1:0]    tb_data = '0;

    always #5 clk = ~clk;

    bomb_fuse_logic dut (
        .clk               (clk),
        .rst               (rst),
        .tick              (tick),
        .game_over         (game_over),
        .place_bomb        (place_bomb),
        .player_x          (player_x),
        .player_y          (player_y),
        .exp_busy          (exp_busy),
        .map_rdata         (map_rdata),
        .map_raddr         (map_raddr),
        .map_we            (map_we),
        .map_waddr         (map_waddr),
        .map_wdata         (map_wdata),
        .trigger_explosion (trigger_explosion),
        .explosion_addr    (explosion_addr),
        .bomb_active       (bomb_active)
    );

    // Map BRAM: one-cycle read latency, DUT writes win over bench preloads.
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 2'd0;
        end else if (map_we) begin
            mem[map_waddr] <= map_wdata;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
        map_rdata <= mem[map_raddr];
    end

    always @(negedge clk) begin
        if (map_we && map_wdata == 2'd3) bomb_wr = bomb_wr + 1;
        if (map_we && map_wdata == 2'd0) free_wr = free_wr + 1;
        if (trigger_explosion) trig_cnt = trig_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int model_addr(input int px, input int py);
        return ((py + SH / 2) / TILE_PX) * NUM_COL + (px + SW / 2) / TILE_PX;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input logic [1:0] v);
        tb_addr = AW'(a);
        tb_data = v;
        tb_we   = 1'b1;
        step();
        tb_we   = 1'b0;
    endtask

    task automatic pick_free(output int px, output int py);
        px = 0;
        py = 0;
        for (int t = 0; t < 64; t++) begin
            px = int'($urandom_range(0, 1199));
            py = int'($urandom_range(0, 679));
            if (mem[model_addr(px, py)] == 2'd0) break;
        end
    endtask

    task automatic place(input int px, input int py, input bit hold, output bit placed);
        int a;
        int bw0;
        a      = model_addr(px, py);
        placed = (mem[a] == 2'd0);
        bw0    = bomb_wr;
        player_x   = 11'(px);
        player_y   = 10'(py);
        place_bomb = 1'b1;
        step();
        if (!hold) place_bomb = 1'b0;
        chk("read_raddr", map_raddr, a);
        chk("read_quiet", {bomb_active, map_we, trigger_explosion}, 0);
        step();
        tick = 1'b0;
        chk("check_we", map_we, placed);
        if (placed) begin
            chk("check_waddr", map_waddr, a);
            chk("check_wdata", map_wdata, 3);
        end
        step();
        chk("placed_active", bomb_active, placed);
        chk("bomb_writes", bomb_wr - bw0, placed);
    endtask

    task automatic run_fuse(input int a, input int busy_hold, input bit toggle);
        int t0;
        int f0;
        int gap;
        t0 = trig_cnt;
        f0 = free_wr;
        for (int i = 0; i < FUSE_TICKS; i++) begin
            chk("fuse_no_early_trig", trig_cnt - t0, 0);
            chk("fuse_active", bomb_active, 1);
            if (i == FUSE_TICKS - 1) begin
                exp_busy = (busy_hold > 0);
                if (toggle) place_bomb = 1'b1;
            end else begin
                exp_busy = 1'($urandom_range(0, 1));
                if (toggle) place_bomb = 1'($urandom_range(0, 1));
            end
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i < FUSE_TICKS - 1) begin
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) step();
            end
        end
        for (int c = 0; c < busy_hold; c++) begin
            chk("wait_no_trig", trigger_explosion, 0);
            chk("wait_active", bomb_active, 1);
            if (c == busy_hold - 1) exp_busy = 1'b0;
            step();
        end
        chk("fire_trig", trigger_explosion, 1);
        chk("fire_addr", explosion_addr, a);
        chk("fire_active", bomb_active, 1);
        step();
        chk("clear_trig", trigger_explosion, 0);
        chk("clear_we", map_we, 1);
        chk("clear_waddr", map_waddr, a);
        chk("clear_wdata", map_wdata, 0);
        step();
        chk("idle_active", bomb_active, 0);
        chk("idle_we", map_we, 0);
        chk("trig_pulses", trig_cnt - t0, 1);
        chk("free_writes", free_wr - f0, 1);
        chk("tile_freed", mem[a], 0);
    endtask

    initial begin
        int  px, py, a, bw0, t0, f0, k;
        bit  placed;

        rst = 1'b1; tick = 1'b0; game_over = 1'b0; place_bomb = 1'b0; exp_busy = 1'b0;
        player_x = '0; player_y = '0; tb_clr = 1'b1;
        repeat (3) step();
        place_bomb = 1'b1; tick = 1'b1; player_x = 11'd500; player_y = 10'd300;
        step();
        chk("rst_active", bomb_active, 0);
        chk("rst_we", map_we, 0);
        chk("rst_trig", trigger_explosion, 0);
        chk("rst_raddr", map_raddr, 0);
        chk("rst_waddr", map_waddr, 0);
        chk("rst_wdata", map_wdata, 0);
        chk("rst_exp_addr", explosion_addr, 0);
        rst = 1'b0; tb_clr = 1'b0; place_bomb = 1'b0; tick = 1'b0;
        step();
        chk("post_rst_idle", {bomb_active, map_we}, 0);

        // Nominal bomb at the sprite-centre tile.
        place(100, 200, 1'b0, placed);
        run_fuse(model_addr(100, 200), 0, 1'b0);

        // Ticks outside FUSE must not shorten the fuse.
        tick = 1'b1;
        repeat (200) step();
        chk("idle_ticks_quiet", bomb_active, 0);
        pick_free(px, py);
        place(px, py, 1'b0, placed);
        run_fuse(model_addr(px, py), 0, 1'b0);

        // Occupied tile: no write, back to idle; then a normal placement.
        px = int'($urandom_range(0, 1199));
        py = int'($urandom_range(0, 679));
        a  = model_addr(px, py);
        poke(a, $urandom_range(0, 1) != 0 ? 2'd2 : 2'd1);
        place(px, py, 1'b0, placed);
        chk("blocked_tile_kept", (mem[a] == 2'd1 || mem[a] == 2'd2), 1);
        pick_free(px, py);
        place(px, py, 1'b0, placed);
        run_fuse(model_addr(px, py), 0, 1'b0);

        // Explosion block busy at expiry.
        pick_free(px, py);
        place(px, py, 1'b0, placed);
        run_fuse(model_addr(px, py), 30, 1'b0);

        // Held press and extra presses during the fuse place exactly one bomb.
        pick_free(px, py);
        place(px, py, 1'b1, placed);
        bw0 = bomb_wr;
        repeat (500) step();
        chk("held_single_bomb", bomb_wr - bw0, 0);
        run_fuse(model_addr(px, py), 0, 1'b1);
        repeat (20) step();
        chk("held_no_replace", bomb_active, 0);
        chk("held_no_rewrite", bomb_wr - bw0, 0);
        place_bomb = 1'b0;
        step();

        // game_over mid-fuse aborts without trigger or clear.
        pick_free(px, py);
        a = model_addr(px, py);
        place(px, py, 1'b0, placed);
        k = int'($urandom_range(1, 170));
        for (int i = 0; i < k; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        t0 = trig_cnt;
        f0 = free_wr;
        game_over = 1'b1;
        step();
        chk("go_active", bomb_active, 0);
        chk("go_we", map_we, 0);
        chk("go_trig", trigger_explosion, 0);
        chk("go_raddr", map_raddr, 0);
        game_over = 1'b0;
        tick = 1'b1;
        repeat (250) step();
        tick = 1'b0;
        chk("go_no_trig", trig_cnt - t0, 0);
        chk("go_no_clear", free_wr - f0, 0);
        chk("go_tile_left", mem[a], 3);
        pick_free(px, py);
        place(px, py, 1'b0, placed);
        run_fuse(model_addr(px, py), int'($urandom_range(0, 5)), 1'b0);

        // A few more random bombs with random busy windows.
        for (int r = 0; r < 3; r++) begin
            pick_free(px, py);
            place(px, py, 1'b0, placed);
            run_fuse(model_addr(px, py), int'($urandom_range(0, 12)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
